lcd_bus_responder: RTL

Panel-side model of the 8080-style parallel LCD bus that our LCD controller drives (chipselect, lcdreset, lcddata, read, write, data_cmd_select, im0). It samples the asynchronous bus strobes in the system clock domain and decodes ILI9341-subset commands. It tracks the column/page address window and emits one pixel (value plus coordinates) per memory write. It also answers the Read-ID command on the shared data bus, so the controller can be checked in hardware and in simulation without a real panel.

---
 rtl/lcd_bus_responder.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_responder.sv
// Panel-side responder for an 8080-style parallel LCD bus.
// Samples the asynchronous bus strobes into clk_clk, decodes an ILI9341 command subset,
// tracks the column/page window and emits one pixel per completed memory write. It also
// answers Read-ID (0xD3) on the shared data bus.
//
// Ports:
//   clk_clk, reset_reset_n        system clock, async active-low reset
//   lcd_chipselect/_write/_read   active-low bus strobes (asynchronous to clk_clk)
//   lcd_data_cmd_select           0 = command byte, 1 = parameter/data
//   lcd_lcdreset                  active-low panel soft reset
//   lcd_im0                       1 = 16-bit bus, 0 = 8-bit bus on lcddata[7:0]
//   lcd_lcddata                   shared data bus, driven only during a read
//   cmd_valid/cmd_code            pulse and value for each received command byte
//   pixel_valid/data/x/y          pulse and value/coordinates for each completed pixel
//   proto_err                     sticky flag: write and read low together under chip select
module lcd_bus_responder #(
    parameter int unsigned WIDTH   = 240,
    parameter int unsigned HEIGHT  = 320,
    parameter logic [15:0] ID_WORD = 16'h9341
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        lcd_chipselect,
    input  logic        lcd_lcdreset,
    input  logic        lcd_write,
    input  logic        lcd_read,
    input  logic        lcd_data_cmd_select,
    input  logic        lcd_im0,
    inout  wire  [15:0] lcd_lcddata,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        proto_err
);

    localparam logic [8:0] XMax     = 9'(WIDTH - 1);
    localparam logic [8:0] YMax     = 9'(HEIGHT - 1);
    localparam logic [7:0] CmdCaset = 8'h2A;
    localparam logic [7:0] CmdPaset = 8'h2B;
    localparam logic [7:0] CmdRamwr = 8'h2C;
    localparam logic [7:0] CmdRamwc = 8'h3C;
    localparam logic [7:0] CmdRdid  = 8'hD3;

    // Two-stage synchronisers: {cs, wr, rd, dc, lcdreset} and the data bus.
    logic [4:0]  ctl_meta_q, ctl_sync_q;
    logic [15:0] dat_meta_q, dat_sync_q;
    logic [2:0]  prev_q;  // previous synced {cs, wr, rd}

    logic cs_s, wr_s, rd_s, dc_s, rst_s;
    assign cs_s  = ctl_sync_q[4];
    assign wr_s  = ctl_sync_q[3];
    assign rd_s  = ctl_sync_q[2];
    assign dc_s  = ctl_sync_q[1];
    assign rst_s = ctl_sync_q[0];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ctl_meta_q <= 5'b11111;
            ctl_sync_q <= 5'b11111;
            dat_meta_q <= 16'h0000;
            dat_sync_q <= 16'h0000;
            prev_q     <= 3'b111;
        end else begin
            ctl_meta_q <= {lcd_chipselect, lcd_write, lcd_read, lcd_data_cmd_select, lcd_lcdreset};
            ctl_sync_q <= ctl_meta_q;
            dat_meta_q <= lcd_lcddata;
            dat_sync_q <= dat_meta_q;
            prev_q     <= {cs_s, wr_s, rd_s};
        end
    end

    // Chip select from the previous cycle keeps a write accepted when CS rises together with
    // the strobe. Requiring the other strobe high in the previous cycle suppresses the edge that
    // ends a write/read conflict.
    logic cs_active, write_evt, read_end_evt, conflict, drive_en;
    assign cs_active    = ~cs_s | ~prev_q[2];
    assign write_evt    = wr_s & ~prev_q[1] & cs_active & prev_q[0];
    assign read_end_evt = rd_s & ~prev_q[0] & cs_active & prev_q[1];
    assign conflict     = ~cs_s & ~wr_s & ~rd_s;
    assign drive_en     = ~cs_s & ~rd_s & wr_s;

    logic        cmd_valid_q, cmd_valid_d, pixel_valid_q, pixel_valid_d;
    logic        proto_err_q, proto_err_d, byte_phase_q, byte_phase_d;
    logic [7:0]  cmd_code_q, cmd_code_d, hi_byte_q, hi_byte_d;
    logic [15:0] pixel_data_q, pixel_data_d;
    logic [8:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [8:0]  sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d, x_q, x_d, y_q, y_d;
    logic [2:0]  param_cnt_q, param_cnt_d, read_idx_q, read_idx_d;
    logic [23:0] par_q, par_d;  // first three window parameter bytes, oldest in [23:16]

    logic [15:0] win_start, win_end, pix_word;
    logic [8:0]  lim, s_clamp, e_clamp;
    logic        pix_done;

    always_comb begin
        cmd_valid_d   = 1'b0;
        pixel_valid_d = 1'b0;
        proto_err_d   = proto_err_q | conflict;
        cmd_code_d    = cmd_code_q;
        hi_byte_d     = hi_byte_q;
        byte_phase_d  = byte_phase_q;
        pixel_data_d  = pixel_data_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        sc_d          = sc_q;
        ec_d          = ec_q;
        sp_d          = sp_q;
        ep_d          = ep_q;
        x_d           = x_q;
        y_d           = y_q;
        param_cnt_d   = param_cnt_q;
        read_idx_d    = read_idx_q;
        par_d         = par_q;
        win_start     = par_q[23:8];
        win_end       = {par_q[7:0], dat_sync_q[7:0]};
        lim           = (cmd_code_q == CmdCaset) ? XMax : YMax;
        s_clamp       = (win_start > {7'd0, lim}) ? lim : win_start[8:0];
        e_clamp       = (win_end > {7'd0, lim}) ? lim : win_end[8:0];
        pix_word      = dat_sync_q;
        pix_done      = 1'b0;

        if (write_evt) begin
            if (!dc_s) begin
                cmd_code_d   = dat_sync_q[7:0];
                cmd_valid_d  = 1'b1;
                param_cnt_d  = 3'd0;
                byte_phase_d = 1'b0;
                read_idx_d   = 3'd0;
                if (dat_sync_q[7:0] == CmdRamwr) begin
                    x_d = sc_q;
                    y_d = sp_q;
                end
            end else begin
                if (param_cnt_q != 3'd4) begin
                    param_cnt_d = param_cnt_q + 3'd1;
                end
                case (cmd_code_q)
                    CmdCaset, CmdPaset: begin
                        if (param_cnt_q < 3'd3) begin
                            par_d = {par_q[15:0], dat_sync_q[7:0]};
                        end else if (param_cnt_q == 3'd3) begin
                            if (s_clamp > e_clamp) begin
                                e_clamp = s_clamp;
                            end
                            if (cmd_code_q == CmdCaset) begin
                                sc_d = s_clamp;
                                ec_d = e_clamp;
                            end else begin
                                sp_d = s_clamp;
                                ep_d = e_clamp;
                            end
                        end
                    end
                    CmdRamwr, CmdRamwc: begin
                        if (lcd_im0) begin
                            pix_done = 1'b1;
                        end else if (!byte_phase_q) begin
                            hi_byte_d    = dat_sync_q[7:0];
                            byte_phase_d = 1'b1;
                        end else begin
                            pix_word     = {hi_byte_q, dat_sync_q[7:0]};
                            pix_done     = 1'b1;
                            byte_phase_d = 1'b0;
                        end
                        if (pix_done) begin
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = pix_word;
                            pixel_x_d     = x_q;
                            pixel_y_d     = y_q;
                            if (x_q < ec_q) begin
                                x_d = x_q + 9'd1;
                            end else begin
                                x_d = sc_q;
                                y_d = (y_q < ep_q) ? y_q + 9'd1 : sp_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (read_end_evt && read_idx_q != 3'd4) begin
            read_idx_d = read_idx_q + 3'd1;
        end

        // Soft reset clears everything but the sticky protocol error.
        if (!rst_s) begin
            cmd_valid_d   = 1'b0;
            pixel_valid_d = 1'b0;
            cmd_code_d    = 8'h00;
            hi_byte_d     = 8'h00;
            byte_phase_d  = 1'b0;
            pixel_data_d  = 16'h0000;
            pixel_x_d     = 9'd0;
            pixel_y_d     = 9'd0;
            sc_d          = 9'd0;
            ec_d          = XMax;
            sp_d          = 9'd0;
            ep_d          = YMax;
            x_d           = 9'd0;
            y_d           = 9'd0;
            param_cnt_d   = 3'd0;
            read_idx_d    = 3'd0;
            par_d         = 24'h0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_valid_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            proto_err_q   <= 1'b0;
            cmd_code_q    <= 8'h00;
            hi_byte_q     <= 8'h00;
            byte_phase_q  <= 1'b0;
            pixel_data_q  <= 16'h0000;
            pixel_x_q     <= 9'd0;
            pixel_y_q     <= 9'd0;
            sc_q          <= 9'd0;
            ec_q          <= XMax;
            sp_q          <= 9'd0;
            ep_q          <= YMax;
            x_q           <= 9'd0;
            y_q           <= 9'd0;
            param_cnt_q   <= 3'd0;
            read_idx_q    <= 3'd0;
            par_q         <= 24'h0;
        end else begin
            cmd_valid_q   <= cmd_valid_d;
            pixel_valid_q <= pixel_valid_d;
            proto_err_q   <= proto_err_d;
            cmd_code_q    <= cmd_code_d;
            hi_byte_q     <= hi_byte_d;
            byte_phase_q  <= byte_phase_d;
            pixel_data_q  <= pixel_data_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            sc_q          <= sc_d;
            ec_q          <= ec_d;
            sp_q          <= sp_d;
            ep_q          <= ep_d;
            x_q           <= x_d;
            y_q           <= y_d;
            param_cnt_q   <= param_cnt_d;
            read_idx_q    <= read_idx_d;
            par_q         <= par_d;
        end
    end

    logic [15:0] rd_word;
    always_comb begin
        rd_word = 16'h0000;
        if (cmd_code_q == CmdRdid) begin
            case (read_idx_q)
                3'd2:    rd_word = {8'h00, ID_WORD[15:8]};
                3'd3:    rd_word = {8'h00, ID_WORD[7:0]};
                default: rd_word = 16'h0000;
            endcase
        end
    end

    assign lcd_lcddata = drive_en ? rd_word : {16{1'bz}};

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign proto_err   = proto_err_q;

endmodule
